// File: rtl/fetch_decode_reg_if.sv
// IF/ID boundary bundle: fetch-side bytes and controls in,
// decode-side instruction slot and interrupt sequencing out.
interface fetch_decode_reg_if;
  logic [7:0] instruction;
  logic [7:0] immediate;
  logic [7:0] pc;
  logic       intr_in;
  logic       d_stall;
  logic       flush;
  logic       immediate_enabled;
  logic       f_stall;
  logic       intr_active;
  logic       intr_ack;
  logic       id_valid;
  logic [7:0] id_instr;
  logic [7:0] id_imm;
  logic [7:0] id_ret_pc;

  modport master (
    output instruction, immediate, pc,
    output intr_in, d_stall, flush,
    input  immediate_enabled, f_stall,
    input  intr_active, intr_ack,
    input  id_valid, id_instr, id_imm, id_ret_pc
  );

  modport slave (
    input  instruction, immediate, pc,
    input  intr_in, d_stall, flush,
    output immediate_enabled, f_stall,
    output intr_active, intr_ack,
    output id_valid, id_instr, id_imm, id_ret_pc
  );
endinterface

// File: rtl/fetch_decode_reg.sv
// IF/ID pipeline register with branch-flush bubbles and
// interrupt entry sequencing (inject push-PC, drain, ack).
module fetch_decode_reg #(
  parameter logic [15:0] IMM_OP_MASK = 16'h1000,
  parameter logic [7:0]  INTR_OPCODE = 8'hB8,
  parameter int unsigned INTR_DRAIN  = 2
) (
  input logic              clk,
  input logic              reset,
  fetch_decode_reg_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    INJECT,
    DRAIN,
    ACK
  } state_t;

  localparam logic [1:0] DRAIN_LAST = 2'(INTR_DRAIN - 1);

  state_t     state;
  logic       pending;
  logic [1:0] drain_cnt;
  logic       active_q;
  logic       ack_q;

  logic       imm_en;
  logic [7:0] ret_pc;
  logic       start_inject;
  logic       enter_ack;

  always_comb begin
    imm_en = IMM_OP_MASK[bus.instruction[7:4]];
    ret_pc = bus.pc + (imm_en ? 8'd2 : 8'd1);
  end

  assign start_inject = (state == IDLE) & pending &
                        ~bus.flush & ~bus.d_stall;

  assign enter_ack = (state == DRAIN) & ~bus.flush &
                     ~bus.d_stall & (drain_cnt == DRAIN_LAST);

  assign bus.immediate_enabled = imm_en;
  assign bus.f_stall           = bus.d_stall | active_q;
  assign bus.intr_active       = active_q;
  assign bus.intr_ack          = ack_q;

  // Clearing on ACK entry keeps a still-high level from re-arming
  // the request that is being serviced.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
    end else if (enter_ack) begin
      pending <= 1'b0;
    end else begin
      pending <= pending | bus.intr_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      drain_cnt <= 2'd0;
      active_q  <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_inject) begin
            state    <= INJECT;
            active_q <= 1'b1;
          end
        end
        INJECT: begin
          drain_cnt <= 2'd0;
          if (bus.flush) begin
            state    <= IDLE;
            active_q <= 1'b0;
          end else begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.flush) begin
            state    <= IDLE;
            active_q <= 1'b0;
          end else if (!bus.d_stall) begin
            if (drain_cnt == DRAIN_LAST) begin
              state <= ACK;
              ack_q <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt + 2'd1;
            end
          end
        end
        ACK: begin
          // Fetch takes the vector on the first unstalled ACK cycle.
          if (bus.flush || !bus.d_stall) begin
            state    <= IDLE;
            active_q <= 1'b0;
            ack_q    <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.id_valid  <= 1'b0;
      bus.id_instr  <= 8'h00;
      bus.id_imm    <= 8'h00;
      bus.id_ret_pc <= 8'h00;
    end else if (bus.flush) begin
      bus.id_valid  <= 1'b0;
      bus.id_instr  <= 8'h00;
      bus.id_imm    <= 8'h00;
      bus.id_ret_pc <= 8'h00;
    end else if (bus.d_stall) begin
      bus.id_valid  <= bus.id_valid;
      bus.id_instr  <= bus.id_instr;
      bus.id_imm    <= bus.id_imm;
      bus.id_ret_pc <= bus.id_ret_pc;
    end else if (start_inject) begin
      // Return to the un-latched pc so it is fetched again.
      bus.id_valid  <= 1'b1;
      bus.id_instr  <= INTR_OPCODE;
      bus.id_imm    <= 8'h00;
      bus.id_ret_pc <= bus.pc;
    end else if (state == IDLE) begin
      bus.id_valid  <= 1'b1;
      bus.id_instr  <= bus.instruction;
      bus.id_imm    <= imm_en ? bus.immediate : 8'h00;
      bus.id_ret_pc <= ret_pc;
    end else begin
      bus.id_valid  <= 1'b0;
      bus.id_instr  <= 8'h00;
      bus.id_imm    <= 8'h00;
      bus.id_ret_pc <= 8'h00;
    end
  end

endmodule

// File: tb/tb_fetch_decode_reg.sv
// Scoreboard bench for fetch_decode_reg: directed scenarios
// followed by random traffic against a sequence-position model.
module tb_fetch_decode_reg;

  localparam int D     = 2;
  localparam int ACKPH = D + 2;

  typedef struct {
    logic       v;
    logic [7:0] i;
    logic [7:0] m;
    logic [7:0] r;
    logic       act;
    logic       ack;
  } reg_exp_t;

  typedef struct {
    logic ie;
    logic fs;
  } comb_exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_decode_reg_if bus();

  fetch_decode_reg #(
    .IMM_OP_MASK(16'h1000),
    .INTR_OPCODE(8'hB8),
    .INTR_DRAIN (D)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  reg_exp_t  rq[$];
  comb_exp_t cq[$];
  int checks  = 0;
  int errors  = 0;
  int ack_cnt = 0;

  logic [15:0] mask = 16'h1000;
  logic        mv, mp;
  logic [7:0]  mi, mm, mr;
  int          ph;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask

  task automatic bubble();
    mv = 1'b0; mi = 8'h00; mm = 8'h00; mr = 8'h00;
  endtask

  // ph: 0 idle, 1 injected, 2..D+1 draining, D+2 acknowledging
  task automatic step(input logic r, input logic fl,
                      input logic ds, input logic iin,
                      input logic [7:0] ins,
                      input logic [7:0] imm,
                      input logic [7:0] p);
    logic ie, np;
    int   nph;
    @(negedge clk);
    reset           = r;
    bus.flush       = fl;
    bus.d_stall     = ds;
    bus.intr_in     = iin;
    bus.instruction = ins;
    bus.immediate   = imm;
    bus.pc          = p;
    #1;
    ie = mask[ins[7:4]];
    cq.push_back('{ie, ds | (ph != 0)});
    if (r) begin
      bubble();
      mp = 1'b0;
      ph = 0;
    end else begin
      np  = mp | iin;
      nph = ph;
      if (fl) bubble();
      else if (ds) begin end
      else if (ph == 0 && mp) begin
        mv = 1'b1; mi = 8'hB8; mm = 8'h00; mr = p;
      end else if (ph == 0) begin
        mv = 1'b1; mi = ins;
        mm = ie ? imm : 8'h00;
        mr = p + (ie ? 8'd2 : 8'd1);
      end else bubble();
      if (ph == 0) nph = (mp && !fl && !ds) ? 1 : 0;
      else if (ph == 1) nph = fl ? 0 : 2;
      else if (ph < ACKPH) nph = fl ? 0 : (ds ? ph : ph + 1);
      else nph = (ds && !fl) ? ph : 0;
      if (nph == ACKPH && ph != ACKPH) np = 1'b0;
      mp = np;
      ph = nph;
    end
    rq.push_back('{mv, mi, mm, mr, ph != 0, ph == ACKPH});
  endtask

  task automatic idle_steps(input int n, input logic [7:0] p);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 8'h05, 8'h00, p);
  endtask

  initial begin : reg_monitor
    reg_exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rq.size() > 0) begin
        e = rq.pop_front();
        chk("id_valid", 32'(bus.id_valid), 32'(e.v));
        chk("id_instr", 32'(bus.id_instr), 32'(e.i));
        chk("id_imm", 32'(bus.id_imm), 32'(e.m));
        chk("id_ret_pc", 32'(bus.id_ret_pc), 32'(e.r));
        chk("intr_active", 32'(bus.intr_active), 32'(e.act));
        chk("intr_ack", 32'(bus.intr_ack), 32'(e.ack));
      end
    end
  end

  initial begin : comb_monitor
    comb_exp_t c;
    forever begin
      @(negedge clk);
      #2;
      if (cq.size() > 0) begin
        c = cq.pop_front();
        chk("imm_enabled", 32'(bus.immediate_enabled), 32'(c.ie));
        chk("f_stall", 32'(bus.f_stall), 32'(c.fs));
      end
      if (bus.intr_ack && !bus.d_stall && !reset) ack_cnt++;
    end
  end

  initial begin
    reset = 1'b1;
    bus.flush = 1'b0; bus.d_stall = 1'b0; bus.intr_in = 1'b0;
    bus.instruction = 8'h10; bus.immediate = 8'h00; bus.pc = 8'h00;
    mv = 1'b0; mi = 8'h00; mm = 8'h00; mr = 8'h00;
    mp = 1'b0; ph = 0;

    for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 8'h10, 8'h00, 8'h00);
    step(0, 0, 0, 0, 8'h10, 8'h00, 8'h00);
    @(posedge clk); #1;
    chk("t1_instr", 32'(bus.id_instr), 32'h10);

    step(0, 0, 0, 0, 8'hC4, 8'h5A, 8'h20);
    chk("t2_imm_en", 32'(bus.immediate_enabled), 32'h1);
    @(posedge clk); #1;
    chk("t2_imm", 32'(bus.id_imm), 32'h5A);
    chk("t2_ret", 32'(bus.id_ret_pc), 32'h22);

    step(0, 0, 1, 0, 8'h33, 8'h44, 8'h21);
    step(0, 0, 1, 0, 8'hC7, 8'h99, 8'h22);
    step(0, 1, 1, 0, 8'h01, 8'h00, 8'h23);
    @(posedge clk); #1;
    chk("t3_flush_valid", 32'(bus.id_valid), 32'h0);

    ack_cnt = 0;
    step(0, 0, 0, 1, 8'h05, 8'h00, 8'h40);
    step(0, 0, 0, 0, 8'h05, 8'h00, 8'h40);
    @(posedge clk); #1;
    chk("t4_instr", 32'(bus.id_instr), 32'hB8);
    chk("t4_ret", 32'(bus.id_ret_pc), 32'h40);
    idle_steps(8, 8'h40);
    @(posedge clk); #1;
    chk("t4_acks", 32'(ack_cnt), 32'd1);

    ack_cnt = 0;
    step(0, 0, 0, 1, 8'h05, 8'h00, 8'h50);
    step(0, 0, 0, 0, 8'h05, 8'h00, 8'h50);
    step(0, 0, 0, 0, 8'h05, 8'h00, 8'h50);
    step(0, 1, 0, 0, 8'h05, 8'h00, 8'h50);
    idle_steps(10, 8'h60);
    @(posedge clk); #1;
    chk("t5_acks", 32'(ack_cnt), 32'd1);

    step(0, 0, 0, 0, 8'hC4, 8'h11, 8'hFF);
    @(posedge clk); #1;
    chk("t6_ret2", 32'(bus.id_ret_pc), 32'h01);
    step(0, 0, 0, 0, 8'h05, 8'h11, 8'hFF);
    @(posedge clk); #1;
    chk("t6_ret1", 32'(bus.id_ret_pc), 32'h00);
    ack_cnt = 0;
    step(0, 0, 0, 1, 8'h05, 8'h00, 8'h70);
    step(0, 0, 0, 0, 8'h05, 8'h00, 8'h70);
    step(0, 0, 0, 0, 8'h05, 8'h00, 8'h70);
    step(1, 0, 0, 0, 8'h05, 8'h00, 8'h70);
    idle_steps(8, 8'h70);
    @(posedge clk); #1;
    chk("t6_acks", 32'(ack_cnt), 32'd0);

    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 63) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 15) == 0,
           8'($urandom), 8'($urandom), 8'($urandom));
    end

    @(posedge clk); #3;
    chk("rq_drained", 32'(rq.size()), 32'd0);
    chk("cq_drained", 32'(cq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
